mux_nto1_reg: RTL and testbench



---
 rtl/dp2_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/mux_nto1_reg.sv | 60 ++++++
 tb/tb_mux_nto1_reg.sv | 106 ++++++++++
 4 files changed

// File: rtl/dp2_pkg.sv
// dp2_pkg: shared mode constants and index helpers for the DP2 channel mux
package dp2_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;
  function automatic int unsigned next_idx(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid channel at or above ptr, wrapping
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  valid,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] idx
);
  logic found;
  logic [SELW-1:0] jj;
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    jj    = '0;
    for (int k = 0; k < NCH; k++) begin
      jj = SELW'((int'(ptr) + k) % NCH);
      if (en && !found && valid[jj]) begin
        found     = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end
endmodule

// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: registered N:1 channel mux with manual or round-robin selection and valid/ready output
module mux_nto1_reg
  import dp2_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);
  logic [WIDTH-1:0] ch_data [NCH];
  logic [NCH-1:0]   rr_grant, man_grant, grant;
  logic [SELW-1:0]  rr_idx, gidx, ptr;
  logic             free, xfer;
  for (genvar i = 0; i < NCH; i++) begin : g_split
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end
  rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_rr (
    .valid (in_valid),
    .ptr   (ptr),
    .en    (mode == MODE_RR),
    .grant (rr_grant),
    .idx   (rr_idx)
  );
  always_comb begin
    man_grant = (int'(sel) < NCH) ? ((NCH'(1) << sel) & in_valid) : '0;
    grant     = (mode == MODE_RR) ? rr_grant : man_grant;
    gidx      = (mode == MODE_RR) ? rr_idx : sel;
    free      = ~out_valid | out_ready;
    in_ready  = (free && !rst) ? grant : '0;
    xfer      = |in_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gidx];
        out_ch    <= gidx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && mode == MODE_RR) ptr <= SELW'(next_idx(32'(gidx), NCH));
    end
  end
endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb_mux_nto1_reg: directed checks of reset, manual select, round-robin, backpressure and reset mid-stall
module tb_mux_nto1_reg;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [1:0]  out_ch;
  int n_cmp = 0;
  int n_bad = 0;
  mux_nto1_reg #(.WIDTH(8), .NCH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; in_data = 32'h4433_2211; in_valid = 4'b1111;
    mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
    step(); step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_ready", 32'(in_ready), 0);
    rst = 1'b0; sel = 2'd2; in_data = 32'h44A5_2211; in_valid = 4'b0100;
    #1 chk("man_ready", 32'(in_ready), 32'b0100);
    step();
    chk("man_data", 32'(out_data), 32'hA5);
    chk("man_ch", 32'(out_ch), 2);
    chk("man_valid", 32'(out_valid), 1);
    sel = 2'd3;
    #1 chk("man_noval", 32'(in_ready), 0);
    step();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_data", 32'(out_data), 32'hA5);
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h4433_2211;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_ch", 32'(out_ch), i % 4);
      chk("rr_data", 32'(out_data), 32'h11 * (i % 4 + 1));
      chk("rr_valid", 32'(out_valid), 1);
    end
    in_valid = 4'b0100;
    step();
    chk("rr_ch2", 32'(out_ch), 2);
    in_valid = 4'b0101;
    #1 chk("wrap_ready", 32'(in_ready), 32'b0001);
    step();
    chk("wrap_ch", 32'(out_ch), 0);
    chk("skip_ready", 32'(in_ready), 32'b0100);
    step();
    chk("skip_ch", 32'(out_ch), 2);
    chk("skip_ready2", 32'(in_ready), 32'b0001);
    step();
    chk("skip_ch0", 32'(out_ch), 0);
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(in_ready), 0);
      step();
      chk("bp_data", 32'(out_data), 32'h11);
      chk("bp_ch", 32'(out_ch), 0);
      chk("bp_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", 32'(in_ready), 32'b0010);
    step();
    chk("bp_ch1", 32'(out_ch), 1);
    chk("bp_data1", 32'(out_data), 32'h22);
    chk("bp_valid1", 32'(out_valid), 1);
    out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_valid", 32'(out_valid), 0);
    chk("rs_data", 32'(out_data), 0);
    chk("rs_ch", 32'(out_ch), 0);
    out_ready = 1'b1;
    #1 chk("rs_ready", 32'(in_ready), 32'b0001);
    step();
    chk("rs_ch0", 32'(out_ch), 0);
    chk("rs_data0", 32'(out_data), 32'h11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
